aes_shift_rows: RTL and testbench
=================================

# aes_shift_rows

AES ShiftRows stage for the AES accelerator datapath. It takes one 128-bit AES state and cyclically rotates each state row by its row index. It sits between SubBytes and MixColumns in the round pipeline. It provides a one-cycle registered output with a simple valid qualifier, and an optional combinational mode.

## Interface
- `REG_OUT`, default 1: 1 = output registered (1-cycle latency); 0 = output purely combinational, `clk`/`rst_n` unused.
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `in_valid`  in  1  — `input_state` is valid this cycle.
- `input_state`  in  128  — AES state.
- `inv`  in  1  — select InvShiftRows. Present only with `SHIFT_ROWS_INV_EN`.
- `out_valid`  out  1  — `output_state` holds a newly produced result.
- `output_state`  out  128  — shifted state.

## Operation
- Byte mapping:
  - Byte k (k = 0..15) is `state[8k+7:8k]`; byte 0 is the LSBs.
  - Row r = k mod 4; column c = k div 4. Column 0 is the least-significant 32 bits.
- Forward mode: `out[r+4c] = in[r+4((c+r) mod 4)]`.
  - Row 0 is unchanged.
  - Rows 1, 2, 3 rotate left by 1, 2, 3 columns.
- Inverse mode (`inv`=1, macro enabled): `out[r+4c] = in[r+4((c−r) mod 4)]`.
- Pure byte permutation: no arithmetic, no byte-value changes.
- No back-pressure: every valid input produces exactly one output.

## Timing
- `REG_OUT`=1:
  - Reset (`rst_n`=0 at a rising edge): `out_valid`=0 and `output_state`=128'h0 on the following cycle.
  - Otherwise, each edge: `out_valid` ← `in_valid`.
  - If `in_valid`=1, `output_state` ← permuted input (latency 1 cycle). If `in_valid`=0, `output_state` holds its previous value.
  - Back-to-back valid inputs produce back-to-back outputs (throughput 1/cycle).
  - Reset asserted mid-stream discards the in-flight result. The first post-reset output appears one cycle after the first post-reset `in_valid`.
  - `inv` is sampled together with `input_state` on the same edge.
- `REG_OUT`=0:
  - `output_state` is a combinational function of `input_state` (and `inv`), settling within the same delta.
  - `out_valid` = `in_valid`.
  - Reset has no effect.

## Configuration
- `SHIFT_ROWS_INV_EN`:
  - Defined: the `inv` port exists and selects forward or inverse permutation per transaction.
  - Undefined: no `inv` port; only the forward permutation is built.

## Structure
- Shared package `aes_pkg`:
  - `typedef logic [127:0] aes_state_t;`
  - `typedef logic [7:0] aes_byte_t;`
  - Constants `AES_NB`=4 and `AES_STATE_BYTES`=16.
  - Helper functions `shift_rows_f` and `inv_shift_rows_f` implementing the index maps above.
- One natural sub-module, `aes_shift_rows_comb`: the combinational permutation. The top level wraps it with the `REG_OUT` register stage and the valid pipeline.

## Test plan
- Forward, known vector: `input_state`=128'h89c2abb23688ac1c675eb2d4cf2a263e, `in_valid`=1 → next cycle `output_state`=128'h365e26b2672aab1ccfc2acd48988b23e, `out_valid`=1.
- Index ramp: 128'h0f0e0d0c0b0a09080706050403020100 → 128'h0b06010c07020d08030e09040f0a0500.
- Inverse (`SHIFT_ROWS_INV_EN`, `inv`=1): 128'h365e26b2672aab1ccfc2acd48988b23e → 128'h89c2abb23688ac1c675eb2d4cf2a263e. A random forward-then-inverse round trip returns the original state.
- Reset behaviour:
  - `rst_n`=0 for 2 cycles with `in_valid`=1 → `out_valid`=0, `output_state`=0.
  - After release, the first output arrives 1 cycle after the first valid input.
- Hold and streaming:
  - Valid pulse, then `in_valid`=0 for 3 cycles → `out_valid` drops and `output_state` holds its value.
  - 4 back-to-back inputs → 4 consecutive correct outputs.
- `REG_OUT`=0: after applying the known forward vector and waiting #1, `output_state`=128'h365e26b2672aab1ccfc2acd48988b23e with no clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// AES shared types, constants and ShiftRows byte-permutation helpers.
// Byte k sits at state[8k+7:8k]; row = k mod 4, column = k div 4.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  localparam int AES_NB          = 4;
  localparam int AES_STATE_BYTES = 16;

  // Row r rotates left by r columns.
  function automatic aes_state_t shift_rows_f(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%AES_NB)) +: 8];
      end
    end
    return o;
  endfunction

  // Row r rotates right by r columns.
  function automatic aes_state_t inv_shift_rows_f(input aes_state_t s);
    aes_state_t o;
    o = '0;
    for (int c = 0; c < AES_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(r+4*c) +: 8] =
          s[8*(r+4*((c-r+AES_NB)%AES_NB)) +: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_shift_rows_comb.sv
// Combinational ShiftRows byte permutation.
// SHIFT_ROWS_INV_EN adds an inv select for InvShiftRows.
module aes_shift_rows_comb
  import aes_pkg::*;
(
`ifdef SHIFT_ROWS_INV_EN
  input  logic         inv,
`endif
  input  logic [127:0] input_state,
  output logic [127:0] output_state
);

`ifdef SHIFT_ROWS_INV_EN
  always_comb begin
    output_state = shift_rows_f(input_state);
    if (inv) output_state = inv_shift_rows_f(input_state);
  end
`else
  always_comb begin
    output_state = shift_rows_f(input_state);
  end
`endif

endmodule

// File: rtl/aes_shift_rows.sv
// AES ShiftRows stage with optional output register (REG_OUT).
// SHIFT_ROWS_INV_EN enables the inv port for InvShiftRows.
module aes_shift_rows
  import aes_pkg::*;
#(
  parameter bit REG_OUT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef SHIFT_ROWS_INV_EN
  input  logic         inv,
`endif
  input  logic         in_valid,
  input  logic [127:0] input_state,
  output logic         out_valid,
  output logic [127:0] output_state
);

  aes_state_t perm;

  aes_shift_rows_comb u_comb (
`ifdef SHIFT_ROWS_INV_EN
    .inv          (inv),
`endif
    .input_state  (input_state),
    .output_state (perm)
  );

  generate
    if (REG_OUT) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid    <= 1'b0;
          output_state <= '0;
        end else begin
          out_valid <= in_valid;
          if (in_valid) output_state <= perm;
        end
      end
    end else begin : g_comb
      // Clock and reset are intentionally idle here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign out_valid      = in_valid;
      assign output_state   = perm;
    end
  endgenerate

endmodule

// File: tb/tb_aes_shift_rows.sv
// Self-checking bench for aes_shift_rows against a row-rotation model.
// Define SHIFT_ROWS_INV_EN to also exercise the inverse permutation.
module tb_aes_shift_rows;

  logic         clk;
  logic         rst_n;
  logic         inv;
  logic         in_valid;
  logic [127:0] input_state;
  logic         out_valid;
  logic [127:0] output_state;

  logic         c_valid;
  logic [127:0] c_state;
  logic         c_out_valid;
  logic [127:0] c_out_state;

  int checks;
  int errors;

  aes_shift_rows #(.REG_OUT(1'b1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SHIFT_ROWS_INV_EN
    .inv          (inv),
`endif
    .in_valid     (in_valid),
    .input_state  (input_state),
    .out_valid    (out_valid),
    .output_state (output_state)
  );

  aes_shift_rows #(.REG_OUT(1'b0)) dut_c (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SHIFT_ROWS_INV_EN
    .inv          (inv),
`endif
    .in_valid     (c_valid),
    .input_state  (c_state),
    .out_valid    (c_out_valid),
    .output_state (c_out_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 4x4 byte matrix, row r rotated one column at a time, r times.
  function automatic logic [127:0] model(input logic [127:0] s,
                                         input bit inverse);
    logic [7:0] m [4][4];
    logic [7:0] t;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) m[k%4][k/4] = s[8*k +: 8];
    for (int r = 1; r < 4; r++) begin
      for (int n = 0; n < r; n++) begin
        if (!inverse) begin
          t = m[r][0];
          for (int c = 0; c < 3; c++) m[r][c] = m[r][c+1];
          m[r][3] = t;
        end else begin
          t = m[r][3];
          for (int c = 3; c > 0; c--) m[r][c] = m[r][c-1];
          m[r][0] = t;
        end
      end
    end
    o = '0;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = m[k%4][k/4];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b1;
    input_state = rnd128();
    repeat (2) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b want 0", out_valid);
    end
    checks++;
    if (output_state !== 128'h0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", output_state);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || output_state !== 128'h0) begin
      errors++;
      $display("FAIL post_release got %b/%h want 0/0",
               out_valid, output_state);
    end
    input_state = rnd128();
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 ||
        output_state !== model(input_state, 1'b0)) begin
      errors++;
      $display("FAIL first_out got %b/%h want 1/%h", out_valid,
               output_state, model(input_state, 1'b0));
    end
  endtask

  task automatic test_known();
    logic [127:0] vin [2];
    logic [127:0] vexp [2];
    vin[0]  = 128'h89c2abb23688ac1c675eb2d4cf2a263e;
    vexp[0] = 128'h365e26b2672aab1ccfc2acd48988b23e;
    vin[1]  = 128'h0f0e0d0c0b0a09080706050403020100;
    vexp[1] = 128'h0b06010c07020d08030e09040f0a0500;
    for (int i = 0; i < 2; i++) begin
      input_state = vin[i];
      in_valid = 1'b1;
      inv = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || output_state !== vexp[i]) begin
        errors++;
        $display("FAIL known_%0d got %b/%h want 1/%h",
                 i, out_valid, output_state, vexp[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [127:0] exp;
    input_state = rnd128();
    exp = model(input_state, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    input_state = rnd128();
    checks++;
    if (out_valid !== 1'b1 || output_state !== exp) begin
      errors++;
      $display("FAIL hold_load got %b/%h want 1/%h",
               out_valid, output_state, exp);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      input_state = rnd128();
      checks++;
      if (out_valid !== 1'b0 || output_state !== exp) begin
        errors++;
        $display("FAIL hold_%0d got %b/%h want 0/%h",
                 i, out_valid, output_state, exp);
      end
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [127:0] q [$];
    logic [127:0] exp;
    in_valid = 1'b1;
    input_state = rnd128();
    q.push_back(model(input_state, 1'b0));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i < n - 1) begin
        input_state = rnd128();
        q.push_back(model(input_state, 1'b0));
      end else begin
        in_valid = 1'b0;
      end
      exp = q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || output_state !== exp) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%h want 1/%h",
                 i, out_valid, output_state, exp);
      end
    end
  endtask

  task automatic test_midstream_reset();
    logic [127:0] exp;
    input_state = rnd128();
    exp = model(input_state, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    input_state = rnd128();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || output_state !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset got %b/%h want 0/0 (prev %h)",
               out_valid, output_state, exp);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle got %b want 0", out_valid);
    end
  endtask

  task automatic test_comb();
    logic [127:0] s;
    c_state = 128'h89c2abb23688ac1c675eb2d4cf2a263e;
    c_valid = 1'b1;
    #1;
    checks++;
    if (c_out_valid !== 1'b1 ||
        c_out_state !== 128'h365e26b2672aab1ccfc2acd48988b23e) begin
      errors++;
      $display("FAIL comb_known got %b/%h want 1/%h", c_out_valid,
               c_out_state, 128'h365e26b2672aab1ccfc2acd48988b23e);
    end
    for (int i = 0; i < 8; i++) begin
      s = rnd128();
      c_state = s;
      c_valid = 1'(i % 2);
      #1;
      checks++;
      if (c_out_valid !== 1'(i % 2) ||
          c_out_state !== model(s, 1'b0)) begin
        errors++;
        $display("FAIL comb_rand_%0d got %b/%h want %0d/%h", i,
                 c_out_valid, c_out_state, i % 2, model(s, 1'b0));
      end
    end
    c_valid = 1'b0;
  endtask

`ifdef SHIFT_ROWS_INV_EN
  task automatic test_inverse();
    logic [127:0] orig;
    logic [127:0] fwd;
    @(negedge clk);
    input_state = 128'h365e26b2672aab1ccfc2acd48988b23e;
    inv = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (output_state !== 128'h89c2abb23688ac1c675eb2d4cf2a263e) begin
      errors++;
      $display("FAIL inv_known got %h want %h", output_state,
               128'h89c2abb23688ac1c675eb2d4cf2a263e);
    end
    for (int i = 0; i < 6; i++) begin
      orig = rnd128();
      input_state = orig;
      inv = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      fwd = output_state;
      checks++;
      if (fwd !== model(orig, 1'b0)) begin
        errors++;
        $display("FAIL rt_fwd_%0d got %h want %h",
                 i, fwd, model(orig, 1'b0));
      end
      input_state = fwd;
      inv = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      inv = 1'b0;
      checks++;
      if (output_state !== orig) begin
        errors++;
        $display("FAIL rt_inv_%0d got %h want %h",
                 i, output_state, orig);
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    inv = 1'b0;
    in_valid = 1'b0;
    input_state = '0;
    c_valid = 1'b0;
    c_state = '0;
    test_reset();
    test_known();
    test_hold();
    test_back_to_back(4);
    test_back_to_back(12);
    test_midstream_reset();
    test_comb();
`ifdef SHIFT_ROWS_INV_EN
    test_inverse();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
